// File: rtl/chroma_key_pipe.sv
// Chroma-key compositor: 3-cycle fixed latency, no backpressure (advances every cycle), shadowed controls at SOF.
// Define SOFT_EDGE_EN for the alpha-ramp soft edge; default build is a hard key with a direct fg/bg mux.
module chroma_key_pipe #(
  parameter int DW           = 10,
  parameter int MARGIN_SHIFT = 2,
  parameter int SOFT_BITS    = 4,
  parameter int CNT_W        = 20,
  parameter int FILL         = 2,
  parameter int TH_RST       = 512
) (
  input  logic             iCLK27,
  input  logic             iRST,
  input  logic             iValid,
  input  logic             iSOF,
  input  logic [DW-1:0]    iRed,
  input  logic [DW-1:0]    iGreen,
  input  logic [DW-1:0]    iBlue,
  input  logic [DW-1:0]    imR,
  input  logic [DW-1:0]    imG,
  input  logic [DW-1:0]    imB,
  input  logic [DW-1:0]    thG,
  input  logic             videoEnable,
  input  logic             imageEnable,
  output logic             oValid,
  output logic [DW-1:0]    oRed,
  output logic [DW-1:0]    oGreen,
  output logic [DW-1:0]    oBlue,
  output logic             oKey,
  output logic [CNT_W-1:0] oKeyCount
);

  localparam int AW = SOFT_BITS + 1;
  localparam logic [AW-1:0] FULL = AW'(1 << SOFT_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
  } pix_t;

  // shadow controls; the SOF pixel itself already uses the freshly captured values
  logic          load;
  logic [DW-1:0] th_sh, th_eff;
  logic          ven_sh, ien_sh, ven_eff, ien_eff;

  assign load    = iValid & iSOF;
  assign th_eff  = load ? thG : th_sh;
  assign ven_eff = load ? videoEnable : ven_sh;
  assign ien_eff = load ? imageEnable : ien_sh;

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      th_sh  <= DW'(TH_RST);
      ven_sh <= 1'b1;
      ien_sh <= 1'b1;
    end else if (load) begin
      th_sh  <= thG;
      ven_sh <= videoEnable;
      ien_sh <= imageEnable;
    end
  end

  // S1: saturating green differences
  pix_t          fg1, bg1;
  logic [DW-1:0] dgr1, dgb1, th1;
  logic          v1, sof1, ven1, ien1;

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      fg1 <= '0; bg1 <= '0; dgr1 <= '0; dgb1 <= '0; th1 <= '0;
      v1 <= 1'b0; sof1 <= 1'b0; ven1 <= 1'b0; ien1 <= 1'b0;
    end else begin
      fg1  <= '{iRed, iGreen, iBlue};
      bg1  <= '{imR, imG, imB};
      dgr1 <= (iGreen > iRed)  ? iGreen - iRed  : '0;
      dgb1 <= (iGreen > iBlue) ? iGreen - iBlue : '0;
      th1  <= th_eff;
      v1   <= iValid;
      sof1 <= load;
      ven1 <= ven_eff;
      ien1 <= ien_eff;
    end
  end

  // S2: key decision
  logic [DW-1:0] m2;
  pix_t          fg2, bg2;
  logic          v2, sof2, ven2, ien2;

  assign m2 = th1 >> MARGIN_SHIFT;

`ifdef SOFT_EDGE_EN
  logic [DW-1:0]        mn;
  logic signed [DW:0]   e;
  logic [AW-1:0]        alpha_c, alpha2;

  always_comb begin
    mn      = (dgr1 < dgb1) ? dgr1 : dgb1;
    e       = $signed({1'b0, mn}) - $signed({1'b0, m2});
    alpha_c = '0;
    if (fg1.g <= th1 || e <= 0)
      alpha_c = '0;
    else if (e >= $signed((DW+1)'(1 << SOFT_BITS)))
      alpha_c = FULL;
    else
      alpha_c = e[AW-1:0];
  end

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) alpha2 <= '0;
    else      alpha2 <= alpha_c;
  end
`else
  logic key_c, key2;

  assign key_c = (fg1.g > th1) & (dgr1 > m2) & (dgb1 > m2);

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) key2 <= 1'b0;
    else      key2 <= key_c;
  end
`endif

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      fg2 <= '0; bg2 <= '0; v2 <= 1'b0; sof2 <= 1'b0; ven2 <= 1'b0; ien2 <= 1'b0;
    end else begin
      fg2 <= fg1; bg2 <= bg1; v2 <= v1; sof2 <= sof1; ven2 <= ven1; ien2 <= ien1;
    end
  end

  // S3: blend and source select
  pix_t mix3, out3;
  logic key3, k3;

`ifdef SOFT_EDGE_EN
  function automatic logic [DW-1:0] blend(input logic [DW-1:0] f, input logic [DW-1:0] b,
                                          input logic [AW-1:0] a);
    logic [DW+SOFT_BITS:0] acc;
    acc = (DW+SOFT_BITS+1)'(f) * (DW+SOFT_BITS+1)'(FULL - a)
        + (DW+SOFT_BITS+1)'(b) * (DW+SOFT_BITS+1)'(a);
    return DW'(acc >> SOFT_BITS);
  endfunction

  assign key3 = (alpha2 != '0);
  assign mix3 = '{blend(fg2.r, bg2.r, alpha2), blend(fg2.g, bg2.g, alpha2), blend(fg2.b, bg2.b, alpha2)};
`else
  assign key3 = key2;
  assign mix3 = key2 ? bg2 : fg2;
`endif

  always_comb begin
    out3 = '{DW'(FILL), DW'(FILL), DW'(FILL)};
    k3   = 1'b0;
    case ({ven2, ien2})
      2'b11: begin out3 = mix3; k3 = key3; end
      2'b10: out3 = fg2;
      2'b01: out3 = bg2;
      default: ;
    endcase
  end

  logic [CNT_W-1:0] cnt;
  logic             seen_sof;

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      oValid <= 1'b0; oKey <= 1'b0;
      oRed <= '0; oGreen <= '0; oBlue <= '0;
    end else begin
      oValid <= v2;
      oKey   <= v2 & k3;
      if (v2) begin
        oRed   <= out3.r;
        oGreen <= out3.g;
        oBlue  <= out3.b;
      end
    end
  end

  // a partial frame after reset is never reported: the first SOF publishes 0
  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      cnt       <= '0;
      oKeyCount <= '0;
      seen_sof  <= 1'b0;
    end else if (v2 & sof2) begin
      oKeyCount <= seen_sof ? cnt : '0;
      cnt       <= CNT_W'(k3);
      seen_sof  <= 1'b1;
    end else if (v2 & k3 & (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
